// File: rtl/bmem_arbiter.sv
// -----------------------------------------------------------------------------
// bmem_arbiter
//
// Shares the single burst memory port (bmem_*) between the instruction cache
// (port 0) and the data cache (port 1). Each grant runs one whole-cacheline
// transaction: either one read request followed by LINE_BEATS returned beats,
// or LINE_BEATS write beats. Only one transaction is in flight at a time.
//
// Configuration macro:
//   BMEM_ARB_RR_EN  defined   -> round-robin between the two ports on contention
//                   undefined -> fixed priority, port 1 (dcache) wins contention
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active low
//   req_addr     per-port line address (low line-offset bits ignored)
//   req_read     per-port line read request, held until req_resp
//   req_write    per-port line write request, held until req_resp
//   req_wdata    per-port write line, beat k = bits [BEAT_W*k +: BEAT_W]
//   req_rdata    per-port read line, valid while req_resp is high
//   req_resp     per-port one-cycle completion pulse
//   bmem_addr    line-aligned address of the current transaction
//   bmem_read    read request strobe
//   bmem_write   write beat strobe
//   bmem_wdata   current write beat
//   bmem_ready   memory accepts the strobe this cycle
//   bmem_raddr   address tag of the returned beat
//   bmem_rdata   returned read beat
//   bmem_rvalid  returned beat valid
// -----------------------------------------------------------------------------
module bmem_arbiter #(
    parameter int BEAT_W     = 64,
    parameter int LINE_BEATS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0][31:0]                      req_addr,
    input  logic [1:0]                            req_read,
    input  logic [1:0]                            req_write,
    input  logic [1:0][BEAT_W*LINE_BEATS-1:0]     req_wdata,
    output logic [1:0][BEAT_W*LINE_BEATS-1:0]     req_rdata,
    output logic [1:0]                            req_resp,
    output logic [31:0]                           bmem_addr,
    output logic                                  bmem_read,
    output logic                                  bmem_write,
    output logic [BEAT_W-1:0]                     bmem_wdata,
    input  logic                                  bmem_ready,
    input  logic [31:0]                           bmem_raddr,
    input  logic [BEAT_W-1:0]                     bmem_rdata,
    input  logic                                  bmem_rvalid
);

    localparam int LINE_W = BEAT_W * LINE_BEATS;
    localparam int CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_REQ     = 3'd1,
        RD_COLLECT = 3'd2,
        WR_BURST   = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t                            state;
    state_t                            state_next;

    logic [CNT_W-1:0]                  beat_cnt;
    logic                              owner;
    logic [31:0]                       addr_q;
    logic [LINE_BEATS-1:0][BEAT_W-1:0] wbuf;
    logic [LINE_BEATS-1:0][BEAT_W-1:0] line_buf;
    logic [1:0][LINE_W-1:0]            rdata_q;

    logic [1:0]                        want;
    logic                              grant_valid;
    logic                              grant_port;
    logic                              last_beat;
    logic                              beat_hit;
    logic                              beat_accept;

`ifdef BMEM_ARB_RR_EN
    logic                              rr_last;
`endif

    // The line-offset bits of the request address never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[0][OFF_W-1:0], req_addr[1][OFF_W-1:0]};

    // -------------------------------------------------------------------------
    // Port selection
    // -------------------------------------------------------------------------
    always_comb begin
        want[0]     = req_read[0] | req_write[0];
        want[1]     = req_read[1] | req_write[1];
        grant_valid = |want;
        grant_port  = want[1];
        if (want == 2'b11) begin
`ifdef BMEM_ARB_RR_EN
            grant_port = ~rr_last;
`else
            grant_port = 1'b1;
`endif
        end
    end

    assign last_beat = (beat_cnt == LAST_BEAT);
    // Beats tagged with another address belong to someone else and are dropped.
    assign beat_hit  = bmem_rvalid && (bmem_raddr == addr_q);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and bmem / response outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_addr   = '0;
        bmem_wdata  = '0;
        req_resp    = 2'b00;
        beat_accept = 1'b0;

        unique case (state)
            IDLE: begin
                // Grant cycle drives nothing; the transaction starts next cycle.
                if (grant_valid) begin
                    // A port raising both read and write is treated as a write.
                    state_next = req_write[grant_port] ? WR_BURST : RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_next = RD_COLLECT;
                end
            end
            RD_COLLECT: begin
                if (beat_hit && last_beat) begin
                    state_next = DONE;
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wbuf[beat_cnt];
                if (bmem_ready) begin
                    beat_accept = 1'b1;
                    if (last_beat) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                req_resp[owner] = 1'b1;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transaction context, beat counter and line buffers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            owner    <= 1'b0;
            addr_q   <= '0;
            wbuf     <= '0;
            line_buf <= '0;
            rdata_q  <= '0;
`ifdef BMEM_ARB_RR_EN
            rr_last  <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant_port;
                        addr_q <= {req_addr[grant_port][31:OFF_W], {OFF_W{1'b0}}};
                        wbuf   <= req_wdata[grant_port];
`ifdef BMEM_ARB_RR_EN
                        rr_last <= grant_port;
`endif
                    end
                end
                RD_COLLECT: begin
                    if (beat_hit) begin
                        line_buf[beat_cnt] <= bmem_rdata;
                        // Counter stays on the last slot; it is cleared in DONE.
                        if (!last_beat) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                WR_BURST: begin
                    if (beat_accept && !last_beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    beat_cnt       <= '0;
                    rdata_q[owner] <= line_buf;
                end
                default: begin
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read line return: the owner sees the live line buffer during DONE, and
    // every port keeps showing the last line it was handed afterwards.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            req_rdata[p] = rdata_q[p];
            if ((state == DONE) && (owner == 1'(p))) begin
                req_rdata[p] = line_buf;
            end
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
module tb_bmem_arbiter;

    localparam int BEAT_W     = 64;
    localparam int LINE_BEATS = 4;
    localparam int LINE_W     = BEAT_W * LINE_BEATS;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            addr0, addr1;
    logic                   rd0, rd1, wr0, wr1;
    logic [LINE_W-1:0]      wd0, wd1;
    logic [1:0][LINE_W-1:0] req_rdata;
    logic [1:0]             req_resp;
    logic [31:0]            bmem_addr;
    logic                   bmem_read;
    logic                   bmem_write;
    logic [BEAT_W-1:0]      bmem_wdata;
    logic                   bmem_ready;
    logic [31:0]            bmem_raddr;
    logic [BEAT_W-1:0]      bmem_rdata;
    logic                   bmem_rvalid;

    always #5 clk = ~clk;

    bmem_arbiter #(.BEAT_W(BEAT_W), .LINE_BEATS(LINE_BEATS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr    ({addr1, addr0}),
        .req_read    ({rd1, rd0}),
        .req_write   ({wr1, wr0}),
        .req_wdata   ({wd1, wd0}),
        .req_rdata   (req_rdata),
        .req_resp    (req_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    typedef struct {
        logic              port;
        logic              is_read;
        logic [LINE_W-1:0] line;
    } resp_t;

    typedef struct {
        logic [31:0]       addr;
        logic [BEAT_W-1:0] data;
    } beat_t;

    resp_t       resp_q[$];
    beat_t       wbeat_q[$];
    logic [31:0] raddr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int reads_accepted = 0;
    int mem_stop_after = 99;
    int mem_bad_at     = -1;

    resp_t             mr;
    beat_t             mb;
    logic [LINE_W-1:0] line3;
    int                cyc;
    int                r0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] gen_beat(input logic [31:0] a, input int k);
        return {a ^ 32'hC0DE_0000, 32'hB0A7_0000 + 32'(k)};
    endfunction

    function automatic logic [LINE_W-1:0] gen_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_BEATS; k++) l[k*BEAT_W +: BEAT_W] = gen_beat(a, k);
        return l;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    task automatic push_read(input int p, input logic [31:0] a);
        resp_t r;
        r.port    = 1'(p);
        r.is_read = 1'b1;
        r.line    = gen_line(align(a));
        raddr_q.push_back(align(a));
        resp_q.push_back(r);
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic rd, input logic wr,
                           input logic [LINE_W-1:0] wd);
        if (p == 0) begin addr0 = a; rd0 = rd; wr0 = wr; wd0 = wd; end
        else        begin addr1 = a; rd1 = rd; wr1 = wr; wd1 = wd; end
    endtask

    task automatic start_read(input int p, input logic [31:0] a);
        push_read(p, a);
        set_req(p, a, 1'b1, 1'b0, '0);
    endtask

    task automatic start_write(input int p, input logic [31:0] a, input logic [LINE_W-1:0] line);
        resp_t r;
        beat_t b;
        for (int k = 0; k < LINE_BEATS; k++) begin
            b.addr = align(a);
            b.data = line[k*BEAT_W +: BEAT_W];
            wbeat_q.push_back(b);
        end
        r.port    = 1'(p);
        r.is_read = 1'b0;
        r.line    = '0;
        resp_q.push_back(r);
        set_req(p, a, 1'b0, 1'b1, line);
    endtask

    // Counts falling edges until port p's response is seen (0 on timeout).
    task automatic wait_resp(input int p, input int budget, output int cycles);
        cycles = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk); #1;
            if (req_resp[p]) begin
                cycles = n;
                break;
            end
        end
        check($sformatf("resp_seen_p%0d", p), cycles != 0, 1'b1);
    endtask

    // Memory model: answers each accepted read with LINE_BEATS tagged beats.
    initial begin : responder
        logic [31:0] a;
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        forever begin
            @(negedge clk); #1;
            if (bmem_read && bmem_ready) begin
                a = bmem_addr;
                for (int k = 0; k < LINE_BEATS && k < mem_stop_after; k++) begin
                    @(negedge clk);
                    if (k == mem_bad_at) begin
                        bmem_rvalid = 1'b1;
                        bmem_raddr  = 32'h0000_3000;
                        bmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
                        @(negedge clk);
                    end
                    bmem_rvalid = 1'b1;
                    bmem_raddr  = a;
                    bmem_rdata  = gen_beat(a, k);
                end
                @(negedge clk);
                bmem_rvalid = 1'b0;
                bmem_raddr  = '0;
                bmem_rdata  = '0;
            end
        end
    end

    // Scoreboard monitor: read requests, write beats and responses.
    initial begin : monitor
        forever begin
            @(negedge clk); #1;
            if (bmem_read && bmem_ready) begin
                reads_accepted++;
                check("rd_queued", raddr_q.size() != 0, 1'b1);
                if (raddr_q.size() != 0) check("rd_addr", bmem_addr, raddr_q.pop_front());
            end
            if (bmem_write && bmem_ready) begin
                check("wr_queued", wbeat_q.size() != 0, 1'b1);
                if (wbeat_q.size() != 0) begin
                    mb = wbeat_q.pop_front();
                    check("wr_addr", bmem_addr, mb.addr);
                    check("wr_data", bmem_wdata, mb.data);
                end
            end
            if (req_resp != 2'b00) begin
                check("resp_queued", resp_q.size() != 0, 1'b1);
                if (resp_q.size() != 0) begin
                    mr = resp_q.pop_front();
                    check("resp_port", req_resp, mr.port ? 2'b10 : 2'b01);
                    if (mr.is_read) check("rdata", req_rdata[mr.port], mr.line);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        addr0 = '0; addr1 = '0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0; wd0 = '0; wd1 = '0;
        bmem_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_bmem_read",  bmem_read,    1'b0);
        check("rst_bmem_write", bmem_write,   1'b0);
        check("rst_bmem_addr",  bmem_addr,    32'h0);
        check("rst_bmem_wdata", bmem_wdata,   64'h0);
        check("rst_resp",       req_resp,     2'b00);
        check("rst_rdata0",     req_rdata[0], '0);
        check("rst_rdata1",     req_rdata[1], '0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // Port 0 line read: IDLE, RD_REQ, 4 beats, DONE.
        r0 = reads_accepted;
        start_read(0, 32'h0000_1000);
        wait_resp(0, 50, cyc);
        check("t1_latency", cyc, LINE_BEATS + 2);
        check("t1_line", req_rdata[0], gen_line(32'h0000_1000));
        set_req(0, '0, 1'b0, 1'b0, '0);
        check("t1_one_read", reads_accepted - r0, 1);
        repeat (3) @(negedge clk); #1;
        check("t1_rdata_hold", req_rdata[0], gen_line(32'h0000_1000));

        // Port 1 line write; request contents change while owned.
        @(negedge clk);
        start_write(1, 32'h0000_2020, {64'd4, 64'd3, 64'd2, 64'd1});
        repeat (2) @(negedge clk);
        addr1 = 32'hFFFF_FFE0;
        wd1   = {4{64'h0BAD_0BAD_0BAD_0BAD}};
        wait_resp(1, 50, cyc);
        check("t2_latency", cyc + 2, LINE_BEATS + 1);
        check("t2_nonowner_hold", req_rdata[0], gen_line(32'h0000_1000));
        set_req(1, '0, 1'b0, 1'b0, '0);

        // Port 0 write with a 3-cycle stall on beat 2, unaligned request address.
        @(negedge clk);
        line3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start_write(0, 32'h0000_404C, line3);
        repeat (3) @(negedge clk);
        bmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall_wdata", bmem_wdata, line3[2*BEAT_W +: BEAT_W]);
            check("t3_stall_addr",  bmem_addr,  32'h0000_4040);
            @(negedge clk);
        end
        bmem_ready = 1'b1;
        wait_resp(0, 50, cyc);
        check("t3_latency", cyc + 6, LINE_BEATS + 1 + 3);
        set_req(0, '0, 1'b0, 1'b0, '0);

        // Foreign-tagged beat in the middle of a read is ignored.
        @(negedge clk);
        mem_bad_at = 2;
        start_read(1, 32'h0000_1000);
        wait_resp(1, 50, cyc);
        check("t5_latency", cyc, LINE_BEATS + 3);
        set_req(1, '0, 1'b0, 1'b0, '0);
        mem_bad_at = -1;

        // Reset in RD_COLLECT after two beats, then a clean read.
        @(negedge clk);
        mem_stop_after = 2;
        raddr_q.push_back(32'h0000_5000);
        set_req(0, 32'h0000_5000, 1'b1, 1'b0, '0);
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk); #1;
            if (bmem_read) begin cyc = n; break; end
        end
        check("t6_read_seen", cyc != 0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_req(0, '0, 1'b0, 1'b0, '0);
        #1;
        check("t6_rst_read",  bmem_read,    1'b0);
        check("t6_rst_write", bmem_write,   1'b0);
        check("t6_rst_addr",  bmem_addr,    32'h0);
        check("t6_rst_resp",  req_resp,     2'b00);
        check("t6_rst_rdata", req_rdata[0], '0);
        repeat (2) @(negedge clk);
        mem_stop_after = 99;
        rst = 1'b1;
        @(negedge clk);
        start_read(0, 32'h0000_6000);
        wait_resp(0, 50, cyc);
        check("t6_latency", cyc, LINE_BEATS + 2);
        set_req(0, '0, 1'b0, 1'b0, '0);

        // Both ports read continuously for three transactions each.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
`ifdef BMEM_ARB_RR_EN
        for (int i = 0; i < 3; i++) begin
            push_read(0, 32'h0001_0000 + 32'(i) * 32'h100);
            push_read(1, 32'h0002_0000 + 32'(i) * 32'h100);
        end
`else
        for (int i = 0; i < 3; i++) push_read(1, 32'h0002_0000 + 32'(i) * 32'h100);
        for (int i = 0; i < 3; i++) push_read(0, 32'h0001_0000 + 32'(i) * 32'h100);
`endif
        fork
            begin : port0_reads
                int c0;
                for (int i = 0; i < 3; i++) begin
                    set_req(0, 32'h0001_0000 + 32'(i) * 32'h100, 1'b1, 1'b0, '0);
                    wait_resp(0, 200, c0);
                end
                set_req(0, '0, 1'b0, 1'b0, '0);
            end
            begin : port1_reads
                int c1;
                for (int i = 0; i < 3; i++) begin
                    set_req(1, 32'h0002_0000 + 32'(i) * 32'h100, 1'b1, 1'b0, '0);
                    wait_resp(1, 200, c1);
                end
                set_req(1, '0, 1'b0, 1'b0, '0);
            end
        join
        repeat (4) @(negedge clk);

        check("sb_resp_empty",  resp_q.size(),  0);
        check("sb_raddr_empty", raddr_q.size(), 0);
        check("sb_wbeat_empty", wbeat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
